score_digit_controller: RTL

//  Owns the packed BCD value that drives the on-screen digit renderer (DIGITS x 4-bit BCD,

---
 rtl/score_digit_controller_pkg.sv | 22 ++
 rtl/score_digit_controller_bcd_digit_add.sv | 26 ++
 rtl/score_digit_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/score_digit_controller_pkg.sv
// Shared definitions for the score digit controller: FSM encodings and BCD limits.
package score_digit_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADD     = 2'd1,
    ST_WAIT_VB = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Addend nibbles above 9 are not legal BCD; treat them as 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    if (d > BCD_MAX_DIGIT) begin
      return BCD_MAX_DIGIT;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/score_digit_controller_bcd_digit_add.sv
// Combinational single-digit BCD adder: a + b + carry-in -> digit + carry-out.
module score_digit_controller_bcd_digit_add
  import score_digit_controller_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [4:0] raw_s;

  // Binary add, then decimal-adjust when the result exceeds one BCD digit.
  always_comb begin
    raw_s = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
    if (raw_s > {1'b0, BCD_MAX_DIGIT}) begin
      s_o = 4'(raw_s - 5'd10);
      c_o = 1'b1;
    end else begin
      s_o = raw_s[3:0];
      c_o = 1'b0;
    end
  end

endmodule

// File: rtl/score_digit_controller.sv
// Score digit controller: arbitrates add/clear requests, adds digit-serially in BCD,
// and publishes the value to the renderer only during vertical blanking.
module score_digit_controller
  import score_digit_controller_pkg::*;
#(
  parameter int DIGITS     = 5,
  parameter int REQUESTERS = 2,
  parameter int V_DISPLAY  = 480
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [9:0]              vpos,
  input  logic [REQUESTERS-1:0]   add_req,
  input  logic [REQUESTERS*8-1:0] add_val,
  output logic [REQUESTERS-1:0]   add_ack,
  input  logic                    clear_req,
  output logic                    clear_ack,
  output logic [DIGITS*4-1:0]     digit_data,
  output logic                    busy,
  output logic                    overflow
);

  localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int K_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS*4-1:0] ALL_NINES = {DIGITS{BCD_MAX_DIGIT}};

  state_e                  state_q, state_d;
  logic [DIGITS*4-1:0]     work_q, work_d;
  logic [7:0]              addend_q, addend_d;
  logic [K_W-1:0]          k_q, k_d;
  logic                    carry_q, carry_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [REQUESTERS-1:0]   add_ack_q, add_ack_d;
  logic                    clear_ack_q, clear_ack_d;
  logic [DIGITS*4-1:0]     digit_data_q, digit_data_d;
  logic                    busy_q, busy_d;
  logic                    overflow_q, overflow_d;

  logic                    grant_valid_s;
  logic [PTR_W-1:0]        grant_s;
  logic [PTR_W-1:0]        cand_s;
  logic [7:0]              addend_sel_s;
  logic [3:0]              cur_digit_s;
  logic [3:0]              addend_digit_s;
  logic [3:0]              sum_digit_s;
  logic                    sum_carry_s;

  // Round-robin: scan requesters starting just above the last grant, wrapping.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = ptr_q;
    cand_s        = ptr_q;
    addend_sel_s  = 8'h00;
    for (int i = 0; i < REQUESTERS; i++) begin
      cand_s = (cand_s == PTR_W'(REQUESTERS - 1)) ? '0 : cand_s + PTR_W'(1);
      if (!grant_valid_s && add_req[cand_s]) begin
        grant_valid_s = 1'b1;
        grant_s       = cand_s;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
    for (int j = 0; j < REQUESTERS; j++) begin
      addend_sel_s = (grant_s == PTR_W'(j)) ? add_val[8*j +: 8] : addend_sel_s;
    end
  end

  // Select the working digit and the matching addend digit for the current index.
  always_comb begin
    cur_digit_s = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      cur_digit_s = (k_q == K_W'(i)) ? work_q[4*i +: 4] : cur_digit_s;
    end
    if (k_q == K_W'(0)) begin
      addend_digit_s = clamp_bcd(addend_q[3:0]);
    end else if (k_q == K_W'(1)) begin
      addend_digit_s = clamp_bcd(addend_q[7:4]);
    end else begin
      addend_digit_s = 4'h0;
    end
  end

  score_digit_controller_bcd_digit_add u_digit_add (
    .a_i (cur_digit_s),
    .b_i (addend_digit_s),
    .c_i (carry_q),
    .s_o (sum_digit_s),
    .c_o (sum_carry_s)
  );

  // Next-state and next-output logic for the IDLE/ADD/WAIT_VB/COMMIT sequence.
  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    addend_d     = addend_q;
    k_d          = k_q;
    carry_d      = carry_q;
    ptr_d        = ptr_q;
    add_ack_d    = '0;
    clear_ack_d  = 1'b0;
    digit_data_d = digit_data_q;
    overflow_d   = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          clear_ack_d = 1'b1;
          work_d      = '0;
          overflow_d  = 1'b0;
          state_d     = ST_WAIT_VB;
        end else if (grant_valid_s) begin
          add_ack_d[grant_s] = 1'b1;
          addend_d           = addend_sel_s;
          k_d                = '0;
          carry_d            = 1'b0;
          ptr_d              = grant_s;
          state_d            = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        for (int i = 0; i < DIGITS; i++) begin
          work_d[4*i +: 4] = (k_q == K_W'(i)) ? sum_digit_s : work_d[4*i +: 4];
        end
        carry_d = sum_carry_s;
        if (k_q == K_W'(DIGITS - 1)) begin
          if (sum_carry_s) begin
            work_d     = ALL_NINES;
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
          state_d = ST_WAIT_VB;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      ST_WAIT_VB: begin
        if (vpos >= 10'(V_DISPLAY)) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_WAIT_VB;
        end
      end
      ST_COMMIT: begin
        digit_data_d = work_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset discards any in-flight add.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      work_q       <= '0;
      addend_q     <= 8'h00;
      k_q          <= '0;
      carry_q      <= 1'b0;
      ptr_q        <= PTR_W'(REQUESTERS - 1);
      add_ack_q    <= '0;
      clear_ack_q  <= 1'b0;
      digit_data_q <= '0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      addend_q     <= addend_d;
      k_q          <= k_d;
      carry_q      <= carry_d;
      ptr_q        <= ptr_d;
      add_ack_q    <= add_ack_d;
      clear_ack_q  <= clear_ack_d;
      digit_data_q <= digit_data_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  assign add_ack    = add_ack_q;
  assign clear_ack  = clear_ack_q;
  assign digit_data = digit_data_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;

endmodule
